// File: rtl/wave_cfg_pkg.sv
// Shared opcodes, FSM state encoding and sizing constants for the wave generator config controller.
package wave_cfg_pkg;

    localparam logic [7:0] OP_CLR_ERR  = 8'h00;
    localparam logic [7:0] OP_SET_DIV  = 8'h01;
    localparam logic [7:0] OP_LOAD_LUT = 8'h02;
    localparam logic [7:0] OP_COMMIT   = 8'h03;

    localparam int unsigned DIV_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV    = 2'd1,
        ST_LUT    = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/wave_lut_shadow.sv
// Shadow sample table: one indexed byte write per cycle, whole table readable at once.
module wave_lut_shadow #(
    parameter int unsigned LUT_SIZE = 4096,
    parameter int unsigned IDX_W    = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [7:0]          wr_data,
    output logic [LUT_SIZE-1:0] rd_data
);

    logic [LUT_SIZE-1:0] lut_q;
    logic [LUT_SIZE-1:0] lut_d;

    always_comb begin
        lut_d = lut_q;
        if (wr_en) begin
            lut_d[{wr_idx, 3'b000} +: 8] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lut_q <= '0;
        end else begin
            lut_q <= lut_d;
        end
    end

    assign rd_data = lut_q;

endmodule

// File: rtl/wave_cfg_ctrl.sv
// Byte-stream parser that stages a clock divider and sample LUT, then commits both atomically.
// Optional WAVE_CFG_AUTOCOMMIT_EN: finishing a LUT load or a non-zero divider commits automatically.
module wave_cfg_ctrl
    import wave_cfg_pkg::*;
#(
    parameter int unsigned LUT_SIZE    = 4096,
    parameter logic [31:0] DEFAULT_DIV = 32'd1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          cmd_byte,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    output logic [31:0]         clk_div_out,
    output logic [LUT_SIZE-1:0] lut_out,
    output logic                busy,
    output logic                err,
    output logic                commit_pulse
);

    localparam int unsigned N_SAMPLES = LUT_SIZE / 8;
    // Counter must also reach the last divider byte when the table is tiny.
    localparam int unsigned CNT_W = ($clog2(N_SAMPLES) > 2) ? $clog2(N_SAMPLES) : 2;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0] LAST_DIV = CNT_W'(DIV_BYTES - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         div_stage_q, div_stage_d;
    logic [31:0]         div_shadow_q, div_shadow_d;
    logic [31:0]         clk_div_q, clk_div_d;
    logic [LUT_SIZE-1:0] lut_act_q, lut_act_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                pulse_q, pulse_d;

    logic                accept_c;
    logic                lut_wr_en_c;
    logic [31:0]         div_asm_c;
    logic [LUT_SIZE-1:0] lut_shadow_c;

    assign accept_c = cmd_valid && ready_q;

    wave_lut_shadow #(
        .LUT_SIZE (LUT_SIZE),
        .IDX_W    (CNT_W)
    ) u_lut_shadow (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (lut_wr_en_c),
        .wr_idx  (cnt_q),
        .wr_data (cmd_byte),
        .rd_data (lut_shadow_c)
    );

    // Next-state, shadow updates and commit.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_stage_d  = div_stage_q;
        div_shadow_d = div_shadow_q;
        clk_div_d    = clk_div_q;
        lut_act_d    = lut_act_q;
        err_d        = err_q;
        pulse_d      = 1'b0;
        lut_wr_en_c  = 1'b0;
        div_asm_c    = div_stage_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    unique case (cmd_byte)
                        OP_CLR_ERR:  err_d = 1'b0;
                        OP_SET_DIV: begin
                            state_d = ST_DIV;
                            cnt_d   = '0;
                        end
                        OP_LOAD_LUT: begin
                            state_d = ST_LUT;
                            cnt_d   = '0;
                        end
                        OP_COMMIT:   state_d = ST_COMMIT;
                        default:     err_d = 1'b1;
                    endcase
                end
            end
            ST_DIV: begin
                if (accept_c) begin
                    div_asm_c[{cnt_q[1:0], 3'b000} +: 8] = cmd_byte;
                    div_stage_d = div_asm_c;
                    cnt_d       = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_DIV) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        // A zero divider would stall the generator; keep the old one.
                        if (div_asm_c == 32'd0) begin
                            err_d = 1'b1;
                        end else begin
                            div_shadow_d = div_asm_c;
`ifdef WAVE_CFG_AUTOCOMMIT_EN
                            state_d = ST_COMMIT;
`endif
                        end
                    end
                end
            end
            ST_LUT: begin
                if (accept_c) begin
                    lut_wr_en_c = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d = '0;
`ifdef WAVE_CFG_AUTOCOMMIT_EN
                        state_d = ST_COMMIT;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_COMMIT: begin
                clk_div_d = div_shadow_q;
                lut_act_d = lut_shadow_c;
                pulse_d   = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d != ST_COMMIT);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            div_stage_q  <= '0;
            div_shadow_q <= DEFAULT_DIV;
            clk_div_q    <= DEFAULT_DIV;
            lut_act_q    <= '0;
            err_q        <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_stage_q  <= div_stage_d;
            div_shadow_q <= div_shadow_d;
            clk_div_q    <= clk_div_d;
            lut_act_q    <= lut_act_d;
            err_q        <= err_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            pulse_q      <= pulse_d;
        end
    end

    assign cmd_ready    = ready_q;
    assign clk_div_out  = clk_div_q;
    assign lut_out      = lut_act_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign commit_pulse = pulse_q;

endmodule

// File: tb/tb_wave_cfg_ctrl.sv
// Randomized self-checking bench for wave_cfg_ctrl against a command-level reference model.
// Honours WAVE_CFG_AUTOCOMMIT_EN when the design is built with it.
module tb_wave_cfg_ctrl;

    localparam int unsigned LUT_SIZE = 4096;
    localparam int unsigned NS       = LUT_SIZE / 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [7:0]          cmd_byte = 8'h00;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [31:0]         clk_div_out;
    logic [LUT_SIZE-1:0] lut_out;
    logic                busy;
    logic                err;
    logic                commit_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit gap_en = 1'b0;

    // Reference model: shadow/active configuration as plain values and byte arrays.
    logic [31:0] m_shadow_div, m_active_div;
    logic [7:0]  m_shadow_lut[NS];
    logic [7:0]  m_active_lut[NS];
    bit          m_err;

    wave_cfg_ctrl #(.LUT_SIZE(LUT_SIZE), .DEFAULT_DIV(32'd1000)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_byte     (cmd_byte),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .clk_div_out  (clk_div_out),
        .lut_out      (lut_out),
        .busy         (busy),
        .err          (err),
        .commit_pulse (commit_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_reset();
        m_shadow_div = 32'd1000;
        m_active_div = 32'd1000;
        m_err = 1'b0;
        for (int k = 0; k < NS; k++) begin
            m_shadow_lut[k] = 8'h00;
            m_active_lut[k] = 8'h00;
        end
    endtask

    // Present one byte and return 1 ns after the edge that transfers it.
    task automatic send_byte(input logic [7:0] b);
        int w;
        if (gap_en) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        cmd_byte  = b;
        cmd_valid = 1'b1;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (w >= 8) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: cmd_ready=%b byte=%h, required 1 within 8 cycles", cmd_ready, b);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic check_lut(input string name);
        int bad = 0;
        for (int k = 0; k < NS; k++)
            if (lut_out[8*k +: 8] !== m_active_lut[k]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s: %0d lut_out bytes differ, required 0", name, bad);
        end
    endtask

    // Called 1 ns after the edge where the design entered COMMIT.
    task automatic check_commit_seq(input string name);
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL %s_ready_low: got %b need 0", name, cmd_ready); end
        n_cmp++; if (commit_pulse !== 1'b0) begin n_bad++; $display("FAIL %s_pulse_early: got %b need 0", name, commit_pulse); end
        n_cmp++; if (clk_div_out !== m_active_div) begin n_bad++; $display("FAIL %s_div_early: got %0d need %0d", name, clk_div_out, m_active_div); end
        m_active_div = m_shadow_div;
        m_active_lut = m_shadow_lut;
        @(posedge clk); #1;
        n_cmp++; if (clk_div_out !== m_active_div) begin n_bad++; $display("FAIL %s_div: got %0d need %0d", name, clk_div_out, m_active_div); end
        n_cmp++; if (commit_pulse !== 1'b1) begin n_bad++; $display("FAIL %s_pulse: got %b need 1", name, commit_pulse); end
        n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL %s_idle: ready=%b busy=%b need 1/0", name, cmd_ready, busy); end
        check_lut({name, "_lut"});
        @(posedge clk); #1;
        n_cmp++; if (commit_pulse !== 1'b0) begin n_bad++; $display("FAIL %s_pulse_one: got %b need 0", name, commit_pulse); end
    endtask

    task automatic cmd_set_div(input logic [31:0] v);
        logic [31:0] tmp;
        tmp = v;
        send_byte(8'h01);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL div_busy: got %b need 1", busy); end
        for (int i = 0; i < 4; i++) begin
            send_byte(tmp[7:0]);
            tmp = tmp >> 8;
        end
        if (v == 32'd0) m_err = 1'b1;
        else m_shadow_div = v;
        n_cmp++; if (err !== m_err) begin n_bad++; $display("FAIL div_err: got %b need %b (v=%0d)", err, m_err, v); end
`ifdef WAVE_CFG_AUTOCOMMIT_EN
        if (v != 32'd0) check_commit_seq("auto_div");
`else
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL div_done_busy: got %b need 0", busy); end
`endif
    endtask

    // mode 0: sample = index[7:0]; mode 1: random samples
    task automatic cmd_load_lut(input int mode);
        logic [7:0] s;
        send_byte(8'h02);
        for (int k = 0; k < NS; k++) begin
            s = (mode == 0) ? 8'(k) : 8'($urandom);
            send_byte(s);
            m_shadow_lut[k] = s;
            if (k == 99) begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lut_partial_busy: got %b need 1", busy); end
                check_lut("lut_partial_unchanged");
            end
        end
`ifdef WAVE_CFG_AUTOCOMMIT_EN
        check_commit_seq("auto_lut");
`else
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lut_done_busy: got %b need 0", busy); end
`endif
    endtask

    task automatic cmd_commit(input string name);
        send_byte(8'h03);
        check_commit_seq(name);
    endtask

    task automatic test_reset();
        cmd_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b need 0", cmd_ready); end
        n_cmp++; if (busy !== 1'b0 || err !== 1'b0 || commit_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_flags: busy=%b err=%b pulse=%b need 0/0/0", busy, err, commit_pulse); end
        n_cmp++; if (clk_div_out !== 32'd1000) begin n_bad++; $display("FAIL rst_div: got %0d need 1000", clk_div_out); end
        check_lut("rst_lut");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b need 1", cmd_ready); end
    endtask

    task automatic test_load_lut();
        cmd_load_lut(0);
`ifndef WAVE_CFG_AUTOCOMMIT_EN
        cmd_commit("lut_commit");
`endif
        n_cmp++; if (lut_out[7:0] !== 8'h00 || lut_out[15:8] !== 8'h01 || lut_out[4095:4088] !== 8'hFF) begin
            n_bad++; $display("FAIL lut_pattern: got %h %h %h need 00 01 ff", lut_out[7:0], lut_out[15:8], lut_out[4095:4088]);
        end
        n_cmp++; if (clk_div_out !== 32'd1000) begin n_bad++; $display("FAIL lut_div_kept: got %0d need 1000", clk_div_out); end
    endtask

    task automatic test_set_div_commit();
        cmd_set_div(32'd10000);
`ifndef WAVE_CFG_AUTOCOMMIT_EN
        cmd_commit("div_commit");
        cmd_commit("recommit");
`endif
        n_cmp++; if (clk_div_out !== 32'd10000) begin n_bad++; $display("FAIL div_10000: got %0d need 10000", clk_div_out); end
    endtask

    task automatic test_back_to_back();
        int c0;
        gap_en = 1'b0;
        send_byte(8'h01);
        c0 = cyc;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        n_cmp++; if (cyc - c0 !== 3) begin n_bad++; $display("FAIL back_to_back: got %0d cycles need 3", cyc - c0); end
        send_byte(8'h00);
        m_shadow_div = 32'h00332211;
`ifdef WAVE_CFG_AUTOCOMMIT_EN
        check_commit_seq("b2b_auto");
`else
        cmd_commit("b2b_commit");
`endif
    endtask

    task automatic test_errors();
        logic [31:0] prev;
        send_byte(8'h7E);
        m_err = 1'b1;
        n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL illegal_op: err=%b busy=%b need 1/0", err, busy); end
        send_byte(8'h00);
        m_err = 1'b0;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL clr_err: got %b need 0", err); end
        prev = m_shadow_div;
        cmd_set_div(32'd0);
        cmd_commit("zero_div_commit");
        n_cmp++; if (clk_div_out !== prev) begin n_bad++; $display("FAIL zero_div_kept: got %0d need %0d", clk_div_out, prev); end
        send_byte(8'h00);
        m_err = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        send_byte(8'hA5);
        m_err = 1'b1;
        send_byte(8'h02);
        for (int k = 0; k < 300; k++) send_byte(8'($urandom));
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        n_cmp++; if (clk_div_out !== 32'd1000 || err !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
            n_bad++; $display("FAIL midrst_outputs: div=%0d err=%b busy=%b ready=%b need 1000/0/0/0", clk_div_out, err, busy, cmd_ready);
        end
        check_lut("midrst_lut");
        @(negedge clk); rst = 1'b0;
        cmd_load_lut(1);
`ifndef WAVE_CFG_AUTOCOMMIT_EN
        cmd_commit("midrst_reload");
`endif
    endtask

    task automatic test_autocommit();
`ifdef WAVE_CFG_AUTOCOMMIT_EN
        cmd_set_div(32'd5);
        n_cmp++; if (clk_div_out !== 32'd5) begin n_bad++; $display("FAIL autocommit_div: got %0d need 5", clk_div_out); end
`else
        int pulses = 0;
        cmd_set_div(32'd5);
        repeat (4) begin
            @(posedge clk); #1;
            if (commit_pulse === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 0 || clk_div_out !== m_active_div) begin
            n_bad++; $display("FAIL no_autocommit: pulses=%0d div=%0d need 0/%0d", pulses, clk_div_out, m_active_div);
        end
`endif
    endtask

    task automatic test_random();
        int op;
        logic [31:0] v;
        logic [7:0] b;
        gap_en = 1'b1;
        for (int it = 0; it < 24; it++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: begin
                    v = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                    cmd_set_div(v);
                end
                1: cmd_load_lut(1);
                2: cmd_commit("rand_commit");
                3: begin
                    b = 8'($urandom_range(4, 255));
                    send_byte(b);
                    m_err = 1'b1;
                    n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL rand_illegal: op=%h err=%b busy=%b need 1/0", b, err, busy); end
                end
                4: begin
                    send_byte(8'h00);
                    m_err = 1'b0;
                    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rand_clr: got %b need 0", err); end
                end
                default: begin
                    repeat ($urandom_range(1, 4)) @(posedge clk);
                    #1;
                    n_cmp++; if (clk_div_out !== m_active_div || err !== m_err) begin
                        n_bad++; $display("FAIL rand_idle: div=%0d err=%b need %0d/%b", clk_div_out, err, m_active_div, m_err);
                    end
                end
            endcase
        end
        cmd_commit("rand_final");
        gap_en = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_lut();
        test_set_div_commit();
        test_back_to_back();
        test_errors();
        test_reset_mid_load();
        test_autocommit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
